seg_deserializer: RTL

SEG_DESERIALIZER -- requirements
Module: seg_deserializer

---
 rtl/seg_deserializer_pkg.sv | 22 ++
 rtl/seg_to_hex.sv | 22 ++
 rtl/seg_deserializer.sv | 98 +++++++++
 3 files changed

// File: rtl/seg_deserializer_pkg.sv
// seg_deserializer_pkg: shared constants, segment table and FSM states
// Contents: SEG_W, DIGITS, FRAME_BITS, CNT_W, SEG_TABLE, state_t
package seg_deserializer_pkg;

    localparam int SEG_W      = 7;
    localparam int DIGITS     = 4;
    localparam int FRAME_BITS = SEG_W * DIGITS;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    // Entry i is the active-low pattern (bit 6 = g .. bit 0 = a) of hex digit i
    localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DECODE
    } state_t;

endpackage

// File: rtl/seg_to_hex.sv
// seg_to_hex: combinational lookup of one active-low 7-segment pattern to a hex nibble
// Ports: seg (pattern g..a), valid (pattern found in table), nibble (digit value, 0 if not found)
module seg_to_hex
    import seg_deserializer_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output logic             valid,
    output logic [3:0]       nibble
);

    always_comb begin
        valid  = 1'b0;
        nibble = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_TABLE[i]) begin
                valid  = 1'b1;
                nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg_deserializer.sv
// seg_deserializer: collects a 28-bit serial 7-segment frame and decodes it to four hex nibbles
// Ports: clk, rst (async active-high); ser_valid/ser_data/ser_sof serial input;
//        out_data/out_err/out_valid held result with out_ready handshake; overrun sticky drop flag
module seg_deserializer
    import seg_deserializer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ser_valid,
    input  logic                 ser_data,
    input  logic                 ser_sof,
    output logic [4*DIGITS-1:0]  out_data,
    output logic [DIGITS-1:0]    out_err,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 overrun
);

    state_t                  state, state_nxt;
    logic [FRAME_BITS-1:0]   sr;
    logic [CNT_W-1:0]        cnt;
    logic [DIGITS-1:0][3:0]  nib;
    logic [DIGITS-1:0]       ok;
    logic                    start;
    logic                    shift;
    logic                    last_bit;
    logic                    load;

    // Digit 3 arrives first, so it ends up in the top slice of the shift register
    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        seg_to_hex u_seg_to_hex (
            .seg    (sr[g*SEG_W +: SEG_W]),
            .valid  (ok[g]),
            .nibble (nib[g])
        );
    end

    // A start-of-frame restarts reception from IDLE or mid-frame; DECODE ignores input
    assign start    = ser_valid && ser_sof && (state != DECODE);
    assign shift    = ser_valid && !ser_sof && (state == RECV);
    assign last_bit = cnt == CNT_W'(FRAME_BITS - 1);
    // The output register is free when empty or being emptied this very cycle
    assign load     = (state == DECODE) && (!out_valid || out_ready);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = start ? RECV : IDLE;
            RECV:    state_nxt = start ? RECV : (shift && last_bit) ? DECODE : RECV;
            DECODE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (start) begin
            sr  <= {{(FRAME_BITS-1){1'b0}}, ser_data};
            cnt <= CNT_W'(1);
        end else if (shift) begin
            sr  <= {sr[FRAME_BITS-2:0], ser_data};
            cnt <= cnt + CNT_W'(1);
        end else if (state == DECODE) begin
            cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_err   <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (load) begin
                out_data  <= nib;
                out_err   <= ~ok;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if ((state == DECODE) && !load) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
